// File: rtl/sub_serial_pkg.sv
// Shared constants and FSM encoding for the byte-serial subtractor.
package sub_serial_pkg;

    localparam int LANE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_8bit_lane.sv
// Combinational lane subtractor: {borrow_next, d} = a - b - borrow.
module sub_8bit_lane
    import sub_serial_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              borrow,
    output logic [LANE_W-1:0] d,
    output logic              borrow_next
);

    logic [LANE_W:0] full;

    // One extra bit on top catches the borrow as the wrapped MSB.
    assign full        = {1'b0, a} - {1'b0, b} - {{LANE_W{1'b0}}, borrow};
    assign d           = full[LANE_W-1:0];
    assign borrow_next = full[LANE_W];

endmodule

// File: rtl/sub_32bit_serial.sv
// Lane-serial WIDTH-bit subtractor: one LANE_W slice per cycle, LSB first, borrow chained.
module sub_32bit_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int LANES = WIDTH / LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  lane_cnt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              borrow;
    logic [LANE_W-1:0] a_lane;
    logic [LANE_W-1:0] b_lane;
    logic [LANE_W-1:0] d_lane;
    logic              borrow_lane;
    logic              accept;
    logic              release_result;
    logic              last_lane;

    // Two's-complement overflow of a - b: operand signs differ and result sign flips away from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    assign in_ready       = (state == IDLE) && !rst;
    assign out_valid      = (state == DONE);
    assign accept         = in_valid && in_ready;
    assign release_result = out_valid && out_ready;
    assign last_lane      = (lane_cnt == LAST_LANE);

    assign a_lane = a_reg[int'(lane_cnt) * LANE_W +: LANE_W];
    assign b_lane = b_reg[int'(lane_cnt) * LANE_W +: LANE_W];

    sub_8bit_lane #(
        .LANE_W (LANE_W)
    ) u_lane (
        .a           (a_lane),
        .b           (b_lane),
        .borrow      (borrow),
        .d           (d_lane),
        .borrow_next (borrow_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (release_result) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt   <= '0;
            borrow     <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        borrow   <= 1'b0;
                        lane_cnt <= '0;
                    end
                end
                RUN: begin
                    diff[int'(lane_cnt) * LANE_W +: LANE_W] <= d_lane;
                    borrow   <= borrow_lane;
                    lane_cnt <= lane_cnt + 1'b1;
                    // The top lane carries the sign bits, so both flags settle here.
                    if (last_lane) begin
                        borrow_out <= borrow_lane;
                        ovf        <= sub_ovf(a_reg[WIDTH-1], b_reg[WIDTH-1], d_lane[LANE_W-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_32bit_serial.sv
// Directed bench for sub_32bit_serial with hand-computed expected results.
module tb_sub_32bit_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        ovf;

    int checks;
    int failures;

    sub_32bit_serial #(
        .WIDTH  (32),
        .LANE_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_diff, input logic exp_bo, input logic exp_ovf);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = 32'h5A5A_5A5A;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_diff"}, diff, exp_diff);
        check({tag, "_borrow"}, 32'(borrow_out), 32'(exp_bo));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;

        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_diff", diff, 32'd0);
        check("post_rst_borrow", 32'(borrow_out), 32'd0);
        check("post_rst_ovf", 32'(ovf), 32'd0);

        run_op("basic",      32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
        run_op("lane1_brw",  32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0);
        run_op("lane3_brw",  32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0, 1'b0);
        run_op("underflow",  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("ovf_neg",    32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("ovf_pos",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        run_op("ovf_min",    32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        run_op("equal",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);

        // Backpressure: hold DONE for 10 cycles while offering a competing operand.
        a        = 32'h0000_0010;
        b        = 32'h0000_0003;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(n), 32'd4);
        a        = 32'd9;
        b        = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff", diff, 32'h0000_000D);
            check("bp_borrow", 32'(borrow_out), 32'd0);
            check("bp_ovf", 32'(ovf), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_diff_kept", diff, 32'h0000_000D);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        run_op("reissue", 32'd9, 32'd1, 32'h0000_0008, 1'b0, 1'b0);

        // Reset after lane 2 has been computed abandons the operation.
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_running", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_diff", diff, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("mid_rst_no_pulse", 32'(n), 32'd0);
        run_op("after_rst", 32'h1234_5678, 32'h0234_5678, 32'h1000_0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_32bit_serial.md
Name: sub_32bit_serial

Overview:
Byte-serial 32-bit unsigned/two's-complement subtractor that computes diff = a - b.
- It processes one LANE_W-bit slice per cycle, LSB slice first, and chains the borrow between slices.
- It is the inverse-direction counterpart of the team's lane-sliced 32-bit adder and reuses the same 8-bit lane granularity.
- Operands enter on a valid/ready input handshake and the result leaves on a valid/ready output handshake. This lets it sit between pipeline stages that tolerate multi-cycle latency.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of LANE_W.
- LANE_W, 8, bits processed per cycle.
- LANES = WIDTH/LANE_W, derived (localparam), 4 by default.

Ports:
- clk  input  1  Single clock; all state changes on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operands a/b are valid.
- in_ready  output  1  Block can accept operands.
- a  input  WIDTH  Minuend.
- b  input  WIDTH  Subtrahend.
- out_valid  output  1  Result is valid.
- out_ready  input  1  Consumer accepts the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow_out  output  1  1 when a < b (unsigned).
- ovf  output  1  Signed overflow.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset while rst=1 at a rising edge:
  - state=IDLE, lane_cnt=0, borrow=0.
  - Operand registers, diff, borrow_out and ovf are all 0.
  - out_valid=0.
  - in_ready=0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !rst. out_valid = (state==DONE).
- IDLE:
  - If in_valid && in_ready at an edge: latch a and b, clear borrow and lane_cnt, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle, computing lane k=lane_cnt:
  - {bo, d} = a[k] - b[k] - borrow, with LANE_W-bit d and 1-bit bo.
  - diff[k] <= d; borrow <= bo; lane_cnt++.
  - When k==LANES-1, go to DONE and register borrow_out <= bo.
  - In the same edge register ovf <= (a[MSB] != b[MSB]) && (d[LANE_W-1] != a[MSB]).
- Latency:
  - out_valid rises exactly LANES edges after the accepting edge (4 by default).
  - Minimum issue interval is LANES+2 cycles, because there is no overlap between operations.
- DONE:
  - diff, borrow_out and ovf are held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE. Outputs keep their values; they are only meaningful while out_valid=1.
- Backpressure: out_ready is ignored outside DONE. in_valid is ignored outside IDLE; no operand is captured.
- Input changes: changes to a/b after acceptance have no effect, because the operands are registered.
- Reset mid-operation (RUN or DONE): the operation is abandoned. No out_valid pulse is produced, and the block returns to IDLE with all outputs zero.
- Result rules:
  - diff wraps modulo 2^WIDTH.
  - borrow_out is the final lane borrow.
  - ovf is the two's-complement overflow of a - b.

Decomposition:
- Package sub_serial_pkg holds the LANE_W default constant and the FSM state enum (IDLE, RUN, DONE).
- Natural sub-module: sub_8bit_lane, a combinational LANE_W-bit subtract with borrow-in and borrow-out, instantiated once.
- The top-level block selects the active lane slice via lane_cnt.

Test Plan:
1. Basic subtraction: a=0x00000005, b=0x00000003 -> diff=0x00000002, borrow_out=0, ovf=0. out_valid is high exactly 4 edges after acceptance.
2. Cross-lane borrow: a=0x00000100, b=0x00000001 -> diff=0x000000FF, borrow_out=0. a=0x01000000, b=1 -> diff=0x00FFFFFF.
3. Full underflow: a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow_out=1, ovf=0.
4. Signed overflow: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, borrow_out=0. a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow_out=1.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> diff, borrow_out, ovf and out_valid stay stable and in_ready=0.
   - A new in_valid with a=9, b=1 during this window is not captured.
   - After out_ready=1 and the re-issued op, diff=0x00000008.
6. Reset mid-RUN: assert rst for one cycle after lane 2 is computed -> next cycle out_valid=0, diff=0, in_ready=1, with no result pulse. A following op a=0x12345678, b=0x02345678 -> diff=0x10000000.
